// File: rtl/cpu_loader.sv
// Front-panel loader: streams a program into a CPU through its address/data strobes,
// starts it, feeds runtime input bytes on request and reports when the CPU halts.
module cpu_loader (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_len,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte,
    output logic       o_byte_ready,
    input  logic       i_in_valid,
    input  logic [7:0] i_in_data,
    output logic       o_in_ready,
    output logic       o_load_addr,
    output logic       o_load_data,
    output logic       o_execute,
    output logic       o_input_taken,
    output logic [7:0] o_data_in,
    input  logic       i_waiting,
    input  logic       i_take_input,
    output logic       o_busy,
    output logic       o_running,
    output logic       o_done
);

    typedef enum logic [3:0] {
        StIdle, StFetch, StAddrWait, StAddrPulse, StDataWait, StDataPulse, StDataRel,
        StExecWait, StExecPulse, StRun, StInFetch, StInPulse, StInRel, StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] len_q, len_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] in_q, in_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        byte_d  = byte_q;
        in_d    = in_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (i_start) begin
                    len_d   = i_len;
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = (i_len == 8'd0) ? StExecWait : StFetch;
                end
            end
            StFetch: begin
                if (i_byte_valid && o_byte_ready) begin
                    byte_d  = i_byte;
                    state_d = StAddrWait;
                end
            end
            StAddrWait: begin
                if (i_waiting) begin
                    cnt_d   = '0;
                    state_d = StAddrPulse;
                end
            end
            StAddrPulse: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd1) begin
                    cnt_d   = '0;
                    state_d = StDataWait;
                end
            end
            StDataWait: begin
                if (i_take_input && !i_waiting) begin
                    cnt_d   = '0;
                    state_d = StDataPulse;
                end
            end
            StDataPulse: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd1) begin
                    cnt_d   = '0;
                    state_d = StDataRel;
                end
            end
            StDataRel: begin
                addr_d  = addr_q + 8'd1;
                state_d = (addr_q + 8'd1 == len_q) ? StExecWait : StFetch;
            end
            StExecWait: begin
                if (i_waiting) begin
                    cnt_d   = '0;
                    state_d = StExecPulse;
                end
            end
            StExecPulse: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd1) begin
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // CPU status is stale for two cycles after a strobe; ignore it until then
                if (cnt_q != 2'd2) begin
                    cnt_d = cnt_q + 2'd1;
                end else if (i_waiting && i_take_input) begin
                    state_d = StInFetch;
                end else if (i_waiting) begin
                    state_d = StDone;
                end
            end
            StInFetch: begin
                if (i_in_valid && o_in_ready) begin
                    in_d    = i_in_data;
                    cnt_d   = '0;
                    state_d = StInPulse;
                end
            end
            StInPulse: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd2) begin
                    cnt_d   = '0;
                    state_d = StInRel;
                end
            end
            StInRel: begin
                if (!i_waiting) begin
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            len_q         <= '0;
            byte_q        <= '0;
            in_q          <= '0;
            cnt_q         <= '0;
            o_byte_ready  <= 1'b0;
            o_in_ready    <= 1'b0;
            o_load_addr   <= 1'b0;
            o_load_data   <= 1'b0;
            o_execute     <= 1'b0;
            o_input_taken <= 1'b0;
            o_data_in     <= '0;
            o_busy        <= 1'b0;
            o_running     <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            byte_q        <= byte_d;
            in_q          <= in_d;
            cnt_q         <= cnt_d;
            o_byte_ready  <= (state_d == StFetch);
            o_in_ready    <= (state_d == StInFetch);
            o_load_addr   <= (state_d == StAddrPulse);
            o_load_data   <= (state_d == StDataPulse);
            o_execute     <= (state_d == StExecPulse);
            o_input_taken <= (state_d == StInPulse) && (cnt_d != 2'd0);
            o_busy        <= (state_d != StIdle);
            o_running     <= (state_d == StRun) || (state_d == StInFetch) ||
                             (state_d == StInPulse) || (state_d == StInRel);
            o_done        <= (state_d == StDone);
            case (state_d)
                StAddrWait, StAddrPulse:             o_data_in <= addr_d;
                StDataWait, StDataPulse, StDataRel:  o_data_in <= byte_d;
                StInPulse, StInRel:                  o_data_in <= in_d;
                default:                             o_data_in <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_loader.sv
// Directed bench for cpu_loader with a small behavioural CPU (front panel, NOP/HALT/write-input).
module tb_cpu_loader;

    logic       i_clk = 1'b0;
    logic       i_reset, i_start, i_byte_valid, i_in_valid, i_waiting, i_take_input;
    logic [7:0] i_len, i_byte, i_in_data, o_data_in;
    logic       o_byte_ready, o_in_ready, o_load_addr, o_load_data, o_execute, o_input_taken;
    logic       o_busy, o_running, o_done;

    always #5 i_clk = ~i_clk;

    cpu_loader dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_len(i_len),
        .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_load_addr(o_load_addr), .o_load_data(o_load_data), .o_execute(o_execute),
        .o_input_taken(o_input_taken), .o_data_in(o_data_in), .i_waiting(i_waiting),
        .i_take_input(i_take_input), .o_busy(o_busy), .o_running(o_running), .o_done(o_done)
    );

    // CPU model: 0x00 halt, 0x02 <addr> write-input, anything else a one-byte NOP.
    logic [7:0] ram [256];
    logic [7:0] cpu_addr, pc;
    logic       cpu_waiting, cpu_run, la_q, ld_q, ex_q, it_q, hold_wait;
    assign i_waiting = cpu_waiting & ~hold_wait;

    always @(posedge i_clk) begin
        la_q <= o_load_addr;
        ld_q <= o_load_data;
        ex_q <= o_execute;
        it_q <= o_input_taken;
        if (i_reset) begin
            cpu_waiting  <= 1'b1;
            i_take_input <= 1'b0;
            cpu_run      <= 1'b0;
            pc           <= 8'h00;
            cpu_addr     <= 8'h00;
            for (int k = 0; k < 256; k++) ram[k] <= 8'h00;
        end else if (o_load_addr && !la_q) begin
            cpu_addr     <= o_data_in;
            cpu_waiting  <= 1'b0;
            i_take_input <= 1'b1;
        end else if (o_load_data && !ld_q) begin
            ram[cpu_addr] <= o_data_in;
            cpu_waiting   <= 1'b1;
            i_take_input  <= 1'b0;
        end else if (o_execute && !ex_q) begin
            pc          <= 8'h00;
            cpu_run     <= 1'b1;
            cpu_waiting <= 1'b0;
        end else if (o_input_taken && !it_q) begin
            ram[cpu_addr] <= o_data_in;
            cpu_waiting   <= 1'b0;
            i_take_input  <= 1'b0;
            cpu_run       <= 1'b1;
            pc            <= pc + 8'd2;
        end else if (cpu_run && !o_execute && !o_input_taken) begin
            case (ram[pc])
                8'h00: begin
                    cpu_run     <= 1'b0;
                    cpu_waiting <= 1'b1;
                end
                8'h02: begin
                    cpu_addr     <= ram[pc + 8'd1];
                    cpu_run      <= 1'b0;
                    cpu_waiting  <= 1'b1;
                    i_take_input <= 1'b1;
                end
                default: pc <= pc + 8'd1;
            endcase
        end
    end

    int         n_run = 0, n_fail = 0;
    logic [7:0] prog [8];
    int         prog_len, byte_idx, stall_idx, stall_left, stall_bad;
    logic       in_pending;
    logic [7:0] in_val;
    int         la_cyc, la_rise, ld_cyc, ld_rise, ex_cyc, ex_rise, it_cyc, it_rise;
    int         done_cyc, multi, ready_seen;
    logic       la_p, ld_p, ex_p, it_p;

    task automatic clear_counts();
        la_cyc = 0; la_rise = 0; ld_cyc = 0; ld_rise = 0; ex_cyc = 0; ex_rise = 0;
        it_cyc = 0; it_rise = 0; done_cyc = 0; multi = 0; ready_seen = 0;
        la_p = 0; ld_p = 0; ex_p = 0; it_p = 0;
    endtask

    // One cycle: sample outputs at the falling edge, tally strobes, drive both streams.
    task automatic step();
        int nstb;
        @(negedge i_clk);
        nstb = int'(o_load_addr) + int'(o_load_data) + int'(o_execute) + int'(o_input_taken);
        if (nstb > 1) multi++;
        la_cyc += int'(o_load_addr);   if (o_load_addr && !la_p) la_rise++;   la_p = o_load_addr;
        ld_cyc += int'(o_load_data);   if (o_load_data && !ld_p) ld_rise++;   ld_p = o_load_data;
        ex_cyc += int'(o_execute);     if (o_execute && !ex_p) ex_rise++;     ex_p = o_execute;
        it_cyc += int'(o_input_taken); if (o_input_taken && !it_p) it_rise++; it_p = o_input_taken;
        done_cyc   += int'(o_done);
        ready_seen += int'(o_byte_ready);
        i_start = 1'b0;
        if (o_byte_ready && stall_left > 0 && byte_idx == stall_idx) begin
            stall_left--;
            if (nstb != 0) stall_bad++;
            i_byte_valid = 1'b0;
        end else if (byte_idx < prog_len) begin
            i_byte_valid = 1'b1;
            i_byte       = prog[byte_idx];
        end else begin
            i_byte_valid = 1'b0;
        end
        if (o_byte_ready && i_byte_valid) byte_idx++;
        i_in_valid = in_pending;
        i_in_data  = in_val;
        if (o_in_ready && i_in_valid) in_pending = 1'b0;
    endtask

    task automatic start_session(input int len, input logic [7:0] b0, b1, b2);
        prog[0] = b0; prog[1] = b1; prog[2] = b2;
        prog_len = len;
        byte_idx = 0;
        clear_counts();
        step();
        i_len   = 8'(len);
        i_start = 1'b1;
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_cyc == 0 && k < 400) begin
            step();
            k++;
        end
        n_run++;
        if (done_cyc == 0) begin
            n_fail++;
            $display("FAIL wait_done: o_done not seen after %0d cycles, required one pulse", k);
        end
        step();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) step();
        n_run++;
        if ({o_busy, o_running, o_done, o_byte_ready, o_in_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_status: got %b required 00000",
                     {o_busy, o_running, o_done, o_byte_ready, o_in_ready});
        end
        n_run++;
        if ({o_load_addr, o_load_data, o_execute, o_input_taken, o_data_in} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %h required 000",
                     {o_load_addr, o_load_data, o_execute, o_input_taken, o_data_in});
        end
        i_reset = 1'b0;
        repeat (3) step();
        n_run++;
        if (o_busy !== 1'b0 || ready_seen != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: busy=%b ready_cycles=%0d required 0 and 0", o_busy, ready_seen);
        end
    endtask

    task automatic test_load();
        start_session(3, 8'h06, 8'h01, 8'h00);
        wait_done();
        for (int a = 0; a < 3; a++) begin
            n_run++;
            if (ram[a] !== prog[a]) begin
                n_fail++;
                $display("FAIL load_ram[%0d]: got %h required %h", a, ram[a], prog[a]);
            end
        end
        n_run++;
        if (la_rise != 3 || la_cyc != 6) begin
            n_fail++;
            $display("FAIL load_addr_pulses: got %0d pulses/%0d cycles required 3/6", la_rise, la_cyc);
        end
        n_run++;
        if (ld_rise != 3 || ld_cyc != 6) begin
            n_fail++;
            $display("FAIL load_data_pulses: got %0d pulses/%0d cycles required 3/6", ld_rise, ld_cyc);
        end
        n_run++;
        if (ex_rise != 1 || ex_cyc != 2) begin
            n_fail++;
            $display("FAIL execute_pulse: got %0d pulses/%0d cycles required 1/2", ex_rise, ex_cyc);
        end
        n_run++;
        if (done_cyc != 1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: done_cycles=%0d busy=%b required 1 and 0", done_cyc, o_busy);
        end
        n_run++;
        if (multi != 0) begin
            n_fail++;
            $display("FAIL load_one_strobe: got %0d overlap cycles required 0", multi);
        end
    endtask

    task automatic test_zero_len();
        hold_wait = 1'b1;
        start_session(0, 8'h00, 8'h00, 8'h00);
        repeat (6) step();
        n_run++;
        if (o_busy !== 1'b1 || ex_cyc != 0 || o_data_in !== 8'h00) begin
            n_fail++;
            $display("FAIL zero_exec_wait: busy=%b exec_cycles=%0d data=%h required 1, 0, 00",
                     o_busy, ex_cyc, o_data_in);
        end
        hold_wait = 1'b0;
        wait_done();
        n_run++;
        if (ex_rise != 1 || ex_cyc != 2) begin
            n_fail++;
            $display("FAIL zero_execute: got %0d pulses/%0d cycles required 1/2", ex_rise, ex_cyc);
        end
        n_run++;
        if (ready_seen != 0 || la_rise != 0 || ld_rise != 0) begin
            n_fail++;
            $display("FAIL zero_no_load: ready=%0d load_addr=%0d load_data=%0d required 0,0,0",
                     ready_seen, la_rise, ld_rise);
        end
    endtask

    task automatic test_write_input();
        in_val     = 8'hA5;
        in_pending = 1'b1;
        start_session(3, 8'h02, 8'h10, 8'h00);
        wait_done();
        n_run++;
        if (ram[8'h10] !== 8'hA5) begin
            n_fail++;
            $display("FAIL input_ram: got %h required a5", ram[8'h10]);
        end
        n_run++;
        if (it_rise != 1 || it_cyc != 2) begin
            n_fail++;
            $display("FAIL input_taken_pulse: got %0d pulses/%0d cycles required 1/2", it_rise, it_cyc);
        end
        n_run++;
        if (done_cyc != 1 || o_busy !== 1'b0 || in_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL input_done: done=%0d busy=%b pending=%b required 1, 0, 0",
                     done_cyc, o_busy, in_pending);
        end
        n_run++;
        if (multi != 0) begin
            n_fail++;
            $display("FAIL input_one_strobe: got %0d overlap cycles required 0", multi);
        end
    endtask

    task automatic test_stall();
        pulse_reset();
        stall_idx  = 1;
        stall_left = 10;
        stall_bad  = 0;
        start_session(3, 8'h06, 8'h01, 8'h00);
        wait_done();
        n_run++;
        if (stall_left != 0 || stall_bad != 0) begin
            n_fail++;
            $display("FAIL stall_quiet: left=%0d strobe_cycles=%0d required 0 and 0",
                     stall_left, stall_bad);
        end
        n_run++;
        if (ram[0] !== 8'h06 || ram[1] !== 8'h01 || ram[2] !== 8'h00) begin
            n_fail++;
            $display("FAIL stall_ram: got %h %h %h required 06 01 00", ram[0], ram[1], ram[2]);
        end
        n_run++;
        if (la_rise != 3 || ld_cyc != 6) begin
            n_fail++;
            $display("FAIL stall_pulses: got %0d addr pulses/%0d data cycles required 3/6",
                     la_rise, ld_cyc);
        end
        stall_left = 0;
    endtask

    task automatic test_reset_mid();
        int k;
        start_session(2, 8'h11, 8'h22, 8'h00);
        k = 0;
        while (o_load_data !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        step();
        n_run++;
        if (o_load_data !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_second_cycle: load_data=%b required 1", o_load_data);
        end
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        n_run++;
        if ({o_busy, o_running, o_done, o_byte_ready, o_in_ready, o_load_addr, o_load_data,
             o_execute, o_input_taken, o_data_in} !== 17'h0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h required 00000",
                     {o_busy, o_running, o_done, o_byte_ready, o_in_ready, o_load_addr,
                      o_load_data, o_execute, o_input_taken, o_data_in});
        end
        start_session(1, 8'h77, 8'h00, 8'h00);
        wait_done();
        n_run++;
        if (ram[0] !== 8'h77 || ram[1] !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reload: got %h %h required 77 00", ram[0], ram[1]);
        end
        n_run++;
        if (la_rise != 1 || ld_rise != 1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reload_pulses: addr=%0d data=%0d busy=%b required 1, 1, 0",
                     la_rise, ld_rise, o_busy);
        end
    endtask

    task automatic test_start_ignored();
        int k;
        start_session(3, 8'h06, 8'h01, 8'h00);
        k = 0;
        while (o_running !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        i_len   = 8'd5;
        i_start = 1'b1;
        step();
        n_run++;
        if (o_running !== 1'b1 || o_byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_run: running=%b ready=%b required 1 and 0",
                     o_running, o_byte_ready);
        end
        wait_done();
        repeat (3) step();
        n_run++;
        if (ready_seen != 3 || la_rise != 3 || done_cyc != 1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored: ready=%0d addr=%0d done=%0d busy=%b required 3, 3, 1, 0",
                     ready_seen, la_rise, done_cyc, o_busy);
        end
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_len = 8'h00;
        i_byte_valid = 1'b0; i_byte = 8'h00; i_in_valid = 1'b0; i_in_data = 8'h00;
        hold_wait = 1'b0; in_pending = 1'b0; in_val = 8'h00;
        prog_len = 0; byte_idx = 0; stall_idx = 0; stall_left = 0; stall_bad = 0;
        clear_counts();
        test_reset();
        test_load();
        test_zero_len();
        test_write_input();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_loader.md
CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 SHALL: i_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: i_reset  in  1  synchronous, active-high reset.
REQ-003 SHALL: i_start  in  1  begin a load-and-run session; sampled only in IDLE.
REQ-004 SHALL: i_len  in  8  program byte count, latched on accepted i_start; 0 = no bytes, go straight to execute.
REQ-005 SHALL: i_byte_valid / i_byte[7:0] in, o_byte_ready out  program byte stream; transfer when valid && ready.
REQ-006 SHALL: i_in_valid / i_in_data[7:0] in, o_in_ready out  runtime input stream for the CPU's write-input instruction; same handshake rule.
REQ-007 SHALL: o_load_addr, o_load_data, o_execute, o_input_taken  out  1 each  CPU front-panel strobes.
REQ-008 SHALL: o_data_in  out  8  CPU data input bus.
REQ-009 SHALL: i_waiting, i_take_input  in  1 each  CPU status outputs.
REQ-010 SHALL: o_busy  out  1  high in every state except IDLE.
REQ-011 SHALL: o_running  out  1  high in RUN, IN_FETCH, IN_PULSE, IN_REL.
REQ-012 SHALL: o_done  out  1  one-cycle pulse when the CPU halts.

Function
REQ-013 SHALL: all outputs registered; strobes, readies, o_done, o_data_in are 0 in IDLE.
REQ-014 SHALL: 8-bit address counter cleared on accepted i_start, incremented after each byte's DATA_REL; 255 max bytes, no wrap.
REQ-015 SHALL: IDLE -> FETCH on i_start (i_len != 0); IDLE -> EXEC_WAIT on i_start (i_len == 0).
REQ-016 SHALL: FETCH: o_byte_ready=1; on transfer latch byte, -> ADDR_WAIT; stall indefinitely otherwise with all strobes 0.
REQ-017 SHALL: ADDR_WAIT: o_data_in=address; -> ADDR_PULSE once i_waiting=1.
REQ-018 SHALL: ADDR_PULSE: o_load_addr=1 for exactly 2 cycles, o_data_in=address held; then -> DATA_WAIT.
REQ-019 SHALL: DATA_WAIT: o_load_addr=0, o_data_in=latched byte; -> DATA_PULSE once i_take_input=1 && i_waiting=0.
REQ-020 SHALL: DATA_PULSE: o_load_data=1 for exactly 2 cycles, byte held; -> DATA_REL.
REQ-021 SHALL: DATA_REL: o_load_data=0, byte held 1 cycle; -> FETCH if bytes remain, else EXEC_WAIT.
REQ-022 SHALL: EXEC_WAIT: o_data_in=0; -> EXEC_PULSE once i_waiting=1; EXEC_PULSE: o_execute=1 for exactly 2 cycles; -> RUN.
REQ-023 SHALL: RUN ignores CPU status for its first 2 cycles (blanking).
REQ-024 SHALL: RUN after blanking: i_take_input=1 && i_waiting=1 -> IN_FETCH; i_waiting=1 && i_take_input=0 -> DONE; IN_FETCH takes priority if both would match.
REQ-025 SHALL: IN_FETCH: o_in_ready=1; on transfer latch i_in_data and drive on o_data_in, -> IN_PULSE; stall otherwise with CPU waiting.
REQ-026 SHALL: IN_PULSE: o_data_in held 1 setup cycle, then o_input_taken=1 for exactly 2 cycles; -> IN_REL.
REQ-027 SHALL: IN_REL: o_input_taken=0; -> RUN (re-entering 2-cycle blanking) once i_waiting=0.
REQ-028 SHALL: DONE: o_done=1 for one cycle; -> IDLE.
REQ-029 SHALL: i_start outside IDLE ignored; never more than one strobe high in any cycle.

Reset
REQ-030 SHALL: i_reset=1 at any edge -> IDLE, counters 0, latched byte/len 0, all outputs 0 the following cycle, including mid-pulse.
REQ-031 SHALL: no stream transfer occurs in the reset cycle (o_byte_ready=o_in_ready=0).

Verification
REQ-032 SHALL: i_len=3, bytes 0x06,0x01,0x00 with CPU model -> CPU RAM[0..2]=06,01,00; o_load_addr/o_load_data each 3 pulses of 2 cycles; one 2-cycle o_execute.
REQ-033 SHALL: i_len=0, i_start -> no o_byte_ready, EXEC_PULSE reached once i_waiting=1.
REQ-034 SHALL: program 0x02,0x10,0x00 (write-input to 0x10, halt), i_in_data=0xA5 -> RAM[0x10]=0xA5, one o_input_taken pulse, o_done one cycle, back to IDLE.
REQ-035 SHALL: i_byte_valid low 10 cycles mid-load -> strobes stay 0, loaded contents identical to no-stall case.
REQ-036 SHALL: reset asserted during second cycle of o_load_data -> next cycle all outputs 0, o_busy=0; fresh i_start reloads from address 0.
REQ-037 SHALL: i_start pulsed while o_running=1 -> no effect on state or outputs.
